// File: rtl/prediction_pkg.sv
// prediction_pkg: shared table/branch constants, decay FSM states and entry index type.
package prediction_pkg;
  localparam int STAT_W = 5;
  localparam int SUB_W = 2;
  localparam logic [1:0] SP = 2'd0, LHP = 2'd1, GHP = 2'd2;
  localparam logic [2:0] BEQ = 3'd5, BNE = 3'd4, BLT = 3'd3, BGE = 3'd2, BLTU = 3'd1, BGEU = 3'd0;
  typedef enum logic [1:0] {IDLE, SWEEP, DONE} decay_state_t;
  typedef struct packed {
    logic [1:0] tbl;
    logic [2:0] addr;
    logic [SUB_W-1:0] sub;
  } entry_idx_t;
endpackage

// File: rtl/prediction_update_scheduler_fifo.sv
// update_fifo: overflow buffer with up to three compacted pushes and two pops per cycle.
module update_fifo #(
  parameter int EW = 15,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [2:0]         push,
  input  logic [2:0][EW-1:0] push_data,
  input  logic [1:0]         pop_n,
  output logic [EW-1:0]      head0,
  output logic [EW-1:0]      head1,
  output logic [CW-1:0]      count
);
  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr, off1, off2;
  assign off1 = AW'(push[0]);
  assign off2 = AW'(push[0]) + AW'(push[1]);
  assign head0 = mem[rd_ptr];
  assign head1 = mem[rd_ptr + AW'(1)];
  always_ff @(posedge clk) begin
    if (push[0]) mem[wr_ptr] <= push_data[0];
    if (push[1]) mem[wr_ptr + off1] <= push_data[1];
    if (push[2]) mem[wr_ptr + off2] <= push_data[2];
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      rd_ptr <= rd_ptr + AW'(pop_n);
      wr_ptr <= wr_ptr + AW'(push[0]) + AW'(push[1]) + AW'(push[2]);
      count <= count + CW'(push[0]) + CW'(push[1]) + CW'(push[2]) - CW'(pop_n);
    end
  end
endmodule

// File: rtl/prediction_update_scheduler.sv
// prediction_update_scheduler: merges three update channels onto two table write ports, with overflow FIFO and decay sweep.
module prediction_update_scheduler
  import prediction_pkg::*;
#(
  parameter int STAT_COUNTER_WIDTH = STAT_W,
  parameter int JUMP_STATUS_COUNTER_WIDTH = SUB_W,
  parameter int FIFO_DEPTH = 4,
  localparam int S = STAT_COUNTER_WIDTH,
  localparam int W = JUMP_STATUS_COUNTER_WIDTH,
  localparam int DW = STAT_COUNTER_WIDTH + 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [2:0]          req_valid,
  input  logic [2:0][1:0]     req_tbl,
  input  logic [2:0][2:0]     req_addr,
  input  logic [2:0][W-1:0]   req_sub,
  input  logic [2:0][DW-1:0]  req_data,
  input  logic                decay_req,
  output logic [1:0]          rd_tbl,
  output logic [2:0]          rd_addr,
  output logic [W-1:0]        rd_sub,
  input  logic [DW-1:0]       rd_data,
  output logic [1:0]          wr_en,
  output logic [1:0][1:0]     wr_tbl,
  output logic [1:0][2:0]     wr_addr,
  output logic [1:0][W-1:0]   wr_sub,
  output logic [1:0][DW-1:0]  wr_data,
  output logic                busy,
  output logic                sweeping,
  output logic                sweep_done,
  output logic                overflow
);
  localparam int KW = 5 + W;
  localparam int EW = KW + DW;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic [EW-1:0] head0, head1;
  logic [CW-1:0] count;
  logic [4:0][EW-1:0] cand;
  logic [4:0] cv, placed;
  logic [1:0][EW-1:0] nxt_e, wr_e;
  logic [1:0] nxt_en, pop_n, used;
  logic [2:0] push;
  logic hit, conflict, sw_go, last, pend, npend;
  decay_state_t state, nstate;
  entry_idx_t idx, nidx, adv;
  update_fifo #(.EW(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push(push), .push_data(cand[4:2]), .pop_n(pop_n),
    .head0(head0), .head1(head1), .count(count)
  );
  assign busy = count > CW'(FIFO_DEPTH - 3);
  assign cv = {req_valid[0] & ~busy, req_valid[1] & ~busy, req_valid[2] & ~busy, count > CW'(1), count != '0};
  assign push = cv[4:2] & ~placed[4:2];
  assign pop_n = 2'(placed[0]) + 2'(placed[1]);
  assign {rd_tbl, rd_addr, rd_sub} = idx;
  assign sweeping = state == SWEEP;
  assign sweep_done = state == DONE;
  always_comb begin
    cand[0] = head0;
    cand[1] = head1;
    for (int i = 0; i < 3; i++) cand[i+2] = {req_tbl[2-i], req_addr[2-i], req_sub[2-i], req_data[2-i]};
  end
  // New requests may bypass the FIFO only when nothing older would stay queued behind them.
  always_comb begin
    placed = '0;
    nxt_en = '0;
    nxt_e = '0;
    used = '0;
    hit = 1'b0;
    conflict = 1'b0;
    for (int i = 0; i < 5; i++) begin
      hit = 1'b0;
      for (int j = 0; j < i; j++) hit = hit | (cv[j] && cand[j][EW-1:DW] == cand[i][EW-1:DW]);
      if (cv[i] && !hit && used != 2'd2 && (i < 2 || count < CW'(2))) begin
        placed[i] = 1'b1;
        nxt_en[used[0]] = 1'b1;
        nxt_e[used[0]] = cand[i];
        used = used + 2'd1;
      end
      conflict = conflict | (placed[i] && cand[i][EW-1:DW] == idx);
    end
    for (int p = 0; p < 2; p++) conflict = conflict | (wr_en[p] && wr_e[p][EW-1:DW] == idx);
    sw_go = state == SWEEP && used != 2'd2 && !conflict;
    if (sw_go) begin
      nxt_en[used[0]] = 1'b1;
      nxt_e[used[0]] = {idx, rd_data[DW-1:S], 1'b0, rd_data[S-1:1]};
    end
  end
  always_comb begin
    last = idx.tbl == GHP && idx.addr == BEQ && idx.sub == '1;
    adv = idx;
    adv.sub = idx.sub + W'(1);
    if (idx.sub == '1) begin
      adv.addr = idx.addr == BEQ ? 3'd0 : idx.addr + 3'd1;
      adv.tbl = idx.addr == BEQ ? idx.tbl + 2'd1 : idx.tbl;
    end
    nstate = state;
    nidx = idx;
    npend = pend;
    unique case (state)
      IDLE: nstate = decay_req ? SWEEP : IDLE;
      SWEEP: begin
        npend = pend | decay_req;
        if (sw_go) begin
          nidx = last ? '0 : adv;
          nstate = last ? DONE : SWEEP;
        end
      end
      DONE: begin
        nstate = pend | decay_req ? SWEEP : IDLE;
        npend = 1'b0;
      end
      default: nstate = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      idx <= '0;
      pend <= 1'b0;
      wr_en <= '0;
      wr_e <= '0;
      overflow <= 1'b0;
    end else begin
      state <= nstate;
      idx <= nidx;
      pend <= npend;
      wr_en <= nxt_en;
      wr_e <= nxt_e;
      overflow <= overflow | (busy && |req_valid);
    end
  end
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      wr_tbl[p] = wr_e[p][EW-1 -: 2];
      wr_addr[p] = wr_e[p][EW-3 -: 3];
      wr_sub[p] = wr_e[p][DW +: W];
      wr_data[p] = wr_e[p][DW-1:0];
    end
  end
endmodule
